// File: rtl/aes_data_mux_if.sv
// aes_data_mux_if: bus bundle between the data-register source mux and its user.
// Parameter DATA_W: data word width in bits (multiple of 8).
// Signals:
//   data_reg_input   - source select (0: ATD_parallel, 1: process_out_data)
//   ATD_parallel     - word assembled by the ATD interface
//   process_out_data - word returned by the processing core
//   load_en          - capture the selected word this cycle
//   data_reg_in      - combinational mux result
//   data_reg_q       - last loaded word
//   src_q            - select value at the last load
//   loaded_q         - sticky "a load happened since reset"
//   byte_parity      - even parity per byte of data_reg_q (AES_DATA_MUX_PARITY_EN only)
// master drives select/data/load_en; slave is the mux itself.
interface aes_data_mux_if #(parameter int DATA_W = 128);
  logic              data_reg_input;
  logic [DATA_W-1:0] ATD_parallel;
  logic [DATA_W-1:0] process_out_data;
  logic              load_en;
  logic [DATA_W-1:0] data_reg_in;
  logic [DATA_W-1:0] data_reg_q;
  logic              src_q;
  logic              loaded_q;
`ifdef AES_DATA_MUX_PARITY_EN
  logic [DATA_W/8-1:0] byte_parity;
  modport master (
    output data_reg_input, ATD_parallel, process_out_data, load_en,
    input  data_reg_in, data_reg_q, src_q, loaded_q, byte_parity
  );
  modport slave (
    input  data_reg_input, ATD_parallel, process_out_data, load_en,
    output data_reg_in, data_reg_q, src_q, loaded_q, byte_parity
  );
`else
  modport master (
    output data_reg_input, ATD_parallel, process_out_data, load_en,
    input  data_reg_in, data_reg_q, src_q, loaded_q
  );
  modport slave (
    input  data_reg_input, ATD_parallel, process_out_data, load_en,
    output data_reg_in, data_reg_q, src_q, loaded_q
  );
`endif
endinterface

// File: rtl/aes_data_mux.sv
// aes_data_mux: source mux and holding register for the cipher data register input.
// Ports: clk (rising-edge clock), rst (synchronous active-high reset),
//   bus (aes_data_mux_if.slave): select, ATD/core words and load_en in;
//   data_reg_in (combinational), data_reg_q, src_q, loaded_q out.
// Optional macro AES_DATA_MUX_PARITY_EN adds a registered per-byte even parity
// of data_reg_q, computed from data_reg_in at load time so it never lags.
module aes_data_mux (
  input logic           clk,
  input logic           rst,
  aes_data_mux_if.slave bus
);
  assign bus.data_reg_in = bus.data_reg_input ? bus.process_out_data : bus.ATD_parallel;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_reg_q <= '0;
      bus.src_q      <= 1'b0;
      bus.loaded_q   <= 1'b0;
    end else if (bus.load_en) begin
      bus.data_reg_q <= bus.data_reg_in;
      bus.src_q      <= bus.data_reg_input;
      bus.loaded_q   <= 1'b1;
    end
  end
`ifdef AES_DATA_MUX_PARITY_EN
  logic [$bits(bus.byte_parity)-1:0] parity_d;
  always_comb begin
    parity_d = '0;
    for (int k = 0; k < $bits(parity_d); k++) parity_d[k] = ^bus.data_reg_in[8*k +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) bus.byte_parity <= '0;
    else if (bus.load_en) bus.byte_parity <= parity_d;
  end
`endif
endmodule

// File: tb/tb_aes_data_mux.sv
// tb_aes_data_mux: randomized self-checking bench for aes_data_mux against a behavioural model.
module tb_aes_data_mux;
  localparam int W = 128;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  bit started = 0;
  logic [W-1:0] m_q;
  logic         m_src;
  logic         m_loaded;
  aes_data_mux_if #(.DATA_W(W)) bus ();
  aes_data_mux dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [W/8-1:0] parity_of(input logic [W-1:0] w);
    logic [W/8-1:0] p;
    for (int k = 0; k < W/8; k++) p[k] = $countones(w[8*k +: 8]) % 2;
    return p;
  endfunction
  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // Model: remembers the last word loaded since reset and which source it came from.
  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_q <= '0;
      m_src <= 1'b0;
      m_loaded <= 1'b0;
    end else if (bus.load_en) begin
      m_q <= bus.data_reg_input ? bus.process_out_data : bus.ATD_parallel;
      m_src <= bus.data_reg_input;
      m_loaded <= 1'b1;
    end
  end
  always @(negedge clk) begin
    chk("mux", bus.data_reg_in, bus.data_reg_input ? bus.process_out_data : bus.ATD_parallel);
    if (started) begin
      chk("data_reg_q", bus.data_reg_q, m_q);
      chk("src_q", W'(bus.src_q), W'(m_src));
      chk("loaded_q", W'(bus.loaded_q), W'(m_loaded));
`ifdef AES_DATA_MUX_PARITY_EN
      chk("byte_parity", W'(bus.byte_parity), W'(parity_of(m_q)));
`endif
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  initial begin
    rst = 1'b1;
    bus.load_en = 1'b0;
    bus.data_reg_input = 1'b0;
    bus.ATD_parallel = W'(69);
    bus.process_out_data = W'(74);
    #1 chk("lit_mux_sel0", bus.data_reg_in, W'(69));
    bus.data_reg_input = 1'b1;
    #1 chk("lit_mux_sel1", bus.data_reg_in, W'(74));
    step();
    bus.data_reg_input = 1'b0;
    #1 chk("lit_mux_in_reset", bus.data_reg_in, W'(69));
    step();
    rst = 1'b0;
    #1;
    chk("lit_rst_q", bus.data_reg_q, '0);
    chk("lit_rst_src", W'(bus.src_q), '0);
    chk("lit_rst_loaded", W'(bus.loaded_q), '0);
    bus.data_reg_input = 1'b1;
    bus.load_en = 1'b1;
    step();
    bus.load_en = 1'b0;
    bus.data_reg_input = 1'b0;
    #1;
    chk("lit_load_q", bus.data_reg_q, W'(74));
    chk("lit_load_src", W'(bus.src_q), W'(1));
    chk("lit_load_loaded", W'(bus.loaded_q), W'(1));
    chk("lit_hold_mux", bus.data_reg_in, W'(69));
    step();
    chk("lit_hold_q", bus.data_reg_q, W'(74));
    rst = 1'b1;
    bus.load_en = 1'b1;
    step();
    chk("lit_rst_prio_q", bus.data_reg_q, '0);
    chk("lit_rst_prio_loaded", W'(bus.loaded_q), '0);
    rst = 1'b0;
    bus.ATD_parallel = {8'h01, 8'h03, 112'h0};
    step();
    bus.load_en = 1'b0;
    chk("lit_par_q", bus.data_reg_q, {8'h01, 8'h03, 112'h0});
`ifdef AES_DATA_MUX_PARITY_EN
    chk("lit_par_bits", W'(bus.byte_parity), W'(16'h8000));
`endif
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 19) == 0);
      bus.load_en = $urandom_range(0, 1);
      bus.data_reg_input = $urandom_range(0, 1);
      bus.ATD_parallel = rnd128();
      bus.process_out_data = rnd128();
      step();
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_data_mux.md
# aes_data_mux

Source selector and holding register for the 128-bit data register input of the cipher datapath. It chooses between the parallel word assembled by the ATD (bus-to-data) interface and the word returned by the processing core. The selected word is driven combinationally to the data register. A registered copy and its provenance flags are also kept for downstream control and debug.

## Interface
Parameters:
- DATA_W, 128, data word width in bits; must be a multiple of 8.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- data_reg_input  input  1  source select; 0 selects ATD_parallel, 1 selects process_out_data.
- ATD_parallel  input  DATA_W  parallel word from the ATD interface.
- process_out_data  input  DATA_W  output word from the processing core.
- load_en  input  1  capture the selected word into the holding register this cycle.
- data_reg_in  output  DATA_W  combinational mux result, feeding the data register.
- data_reg_q  output  DATA_W  registered copy of the last loaded word.
- src_q  output  1  value of data_reg_input at the last load.
- loaded_q  output  1  high once at least one load has occurred since reset.
- byte_parity  output  DATA_W/8  even parity per byte of data_reg_q; present only with AES_DATA_MUX_PARITY_EN.

## Operation
- data_reg_in equals ATD_parallel when data_reg_input=0, and process_out_data when data_reg_input=1.
- data_reg_in is purely combinational and has no dependence on clk, rst or load_en. It is valid during reset.
- Load: on a rising edge with rst=0 and load_en=1, the block captures:
  - data_reg_q ← data_reg_in
  - src_q ← data_reg_input
  - loaded_q ← 1
- With load_en=0, all registers hold their values.
- loaded_q is sticky until the next reset.
- No state machine; the only state is the holding register and its two flags.
- Full-width pass-through: no truncation, extension or bit reordering. Bit i of the output comes from bit i of the selected source.

## Timing
- data_reg_in: zero-cycle latency, settling within the same delta/combinational path as a select or data change.
- data_reg_q, src_q, loaded_q: the new value is visible one clock after the edge on which load_en is sampled high.
- Reset values: data_reg_q = 0, src_q = 0, loaded_q = 0, byte_parity = all 0.
- rst has priority: rst=1 with load_en=1 on the same edge results in the reset values, and no load occurs.
- If rst is asserted mid-operation, the next edge clears all registers. data_reg_in keeps tracking its inputs.
- Select and data changing on the same edge as load_en: the values sampled at that edge are captured.
- Back-to-back loads (load_en held high) capture every cycle.

## Configuration
- AES_DATA_MUX_PARITY_EN defined:
  - The byte_parity port exists.
  - byte_parity[k] = XOR of data_reg_q[8k+7:8k].
  - It is registered together with data_reg_q, computed from data_reg_in at load time, so it never lags data_reg_q.
- AES_DATA_MUX_PARITY_EN undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- ATD_parallel=69, process_out_data=74, data_reg_input=0 → data_reg_in=69 within 1 ns, with no clock edge required.
- Same data with data_reg_input=1 → data_reg_in=74 within 1 ns.
- rst=1 for 2 cycles, then release → data_reg_q=0, src_q=0, loaded_q=0. Throughout reset, data_reg_in continues to follow the select.
- Select=1, data as above, load_en=1 for one edge → next cycle data_reg_q=74, src_q=1, loaded_q=1. Then load_en=0 and the select flips to 0 → data_reg_q stays 74 while data_reg_in=69.
- rst=1 and load_en=1 on the same edge with select=0 → data_reg_q=0 and loaded_q=0, not 69.
- With the macro defined, load ATD_parallel=128'h01_03_00…00 (MSB bytes) → byte_parity[15]=1, byte_parity[14]=0, all others 0, in the same cycle data_reg_q updates.
